// File: rtl/debounce_pkg.sv
// Shared types and defaults for the pin-input debounce path.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_TO_HIGH = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_TO_LOW = 2'd3
  } state_t;

  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int DEFAULT_CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin, synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw pin into a clean registered level with single-cycle rise/fall pulses.
//   state       | meaning
//   LOW_STABLE  | q=0, synchronized input agrees
//   LOW_TO_HIGH | q=0, counting consecutive high samples
//   HIGH_STABLE | q=1, synchronized input agrees
//   HIGH_TO_LOW | q=1, counting consecutive low samples
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic q,
  output logic qb,
  output logic rise,
  output logic fall
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("debounce_edge: STABLE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync2;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (sync2)
  );

  // cnt is 0 in the stable states, so STABLE_CYCLES=1 completes directly from them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOW_STABLE;
      cnt   <= '0;
      q     <= 1'b0;
      qb    <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW_STABLE, LOW_TO_HIGH: begin
          if (!sync2) begin
            state <= LOW_STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= HIGH_STABLE;
            cnt   <= '0;
            q     <= 1'b1;
            qb    <= 1'b0;
            rise  <= 1'b1;
          end else begin
            state <= LOW_TO_HIGH;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        HIGH_STABLE, HIGH_TO_LOW: begin
          if (sync2) begin
            state <= HIGH_STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= LOW_STABLE;
            cnt   <= '0;
            q     <= 1'b0;
            qb    <= 1'b1;
            fall  <= 1'b1;
          end else begin
            state <= HIGH_TO_LOW;
            cnt   <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: run-length model of the debounce rule plus directed literal checks.
module tb_debounce_edge;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic q4, qb4, r4, f4;
  logic q1, qb1, r1, f1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_edge #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in(din), .q(q4), .qb(qb4), .rise(r4), .fall(f4)
  );

  debounce_edge #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in(din), .q(q1), .qb(qb1), .rise(r1), .fall(f1)
  );

  function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got q/qb/rise/fall=%b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: the input reaches the filter two edges late; q flips once the filter
  // has seen STABLE_CYCLES consecutive samples disagreeing with q.
  int stable_of [2] = '{4, 1};
  bit hist [$];
  bit m_q [2];
  bit m_rise [2];
  bit m_fall [2];
  int run [2];
  bit valid = 1'b0;

  always @(posedge clk) begin
    bit obs;
    if (reset) begin
      hist = '{1'b0, 1'b0};
      for (int m = 0; m < 2; m++) begin
        m_q[m] = 1'b0; m_rise[m] = 1'b0; m_fall[m] = 1'b0; run[m] = 0;
      end
      valid = 1'b1;
    end else if (valid) begin
      obs = hist[0];
      void'(hist.pop_front());
      hist.push_back(din);
      for (int m = 0; m < 2; m++) begin
        m_rise[m] = 1'b0;
        m_fall[m] = 1'b0;
        if (obs != m_q[m]) run[m]++;
        else run[m] = 0;
        if (run[m] == stable_of[m]) begin
          m_q[m]    = ~m_q[m];
          m_rise[m] = m_q[m];
          m_fall[m] = ~m_q[m];
          run[m]    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      check("model_s4", {q4, qb4, r4, f4}, {m_q[0], ~m_q[0], m_rise[0], m_fall[0]});
      check("model_s1", {q1, qb1, r1, f1}, {m_q[1], ~m_q[1], m_rise[1], m_fall[1]});
    end
  end

  task automatic step(input logic r, input logic i);
    reset = r;
    din   = i;
    @(negedge clk);
  endtask

  initial begin
    // reset held with in=1
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1);
      check("reset_s4", {q4, qb4, r4, f4}, 4'b0100);
      check("reset_s1", {q1, qb1, r1, f1}, 4'b0100);
    end
    // release with in=1: rise at 6th edge (S=4), 3rd edge (S=1)
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1);
      check("rise_s4", {q4, qb4, r4, f4}, {k >= 6, k < 6, k == 6, 1'b0});
      check("rise_s1", {q1, qb1, r1, f1}, {k >= 3, k < 3, k == 3, 1'b0});
    end
    // fall
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b0);
      check("fall_s4", {q4, qb4, r4, f4}, {k < 6, k >= 6, 1'b0, k == 6});
      check("fall_s1", {q1, qb1, r1, f1}, {k < 3, k >= 3, 1'b0, k == 3});
    end
    // glitch of 3 clocks is rejected by S=4
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, k <= 3);
      check("glitch_s4", {q4, qb4, r4, f4}, 4'b0100);
    end
    check("glitch_state", {2'b00, dut.state}, {2'b00, LOW_STABLE});
    // bounce 1,0,1,0 then held 1: one rise, 5 edges after the final capture
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, k[0]);
      check("bounce_s4", {q4, qb4, r4, f4}, 4'b0100);
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1);
      check("settle_s4", {q4, qb4, r4, f4}, {k >= 6, k < 6, k == 6, 1'b0});
    end
    // reset mid-qualification at E3, release at E4
    step(1'b1, 1'b0);
    check("clear_s4", {q4, qb4, r4, f4}, 4'b0100);
    for (int k = 1; k <= 12; k++) begin
      step(k == 3, 1'b1);
      check("midrst_s4", {q4, qb4, r4, f4}, {k >= 9, k < 9, k == 9, 1'b0});
      check("midrst_s1", {q1, qb1, r1, f1}, {k >= 6, k < 6, k == 6, 1'b0});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
